// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: register file, shift-carry flag, and a one-entry
// operand register with write-back bypass at read time and while stalled.
module alu_operand_stage #(
  parameter int unsigned A  = 3,
  parameter int unsigned D  = 8,
  parameter int unsigned RA = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [A:0]    in_cmd,
  input  logic [RA-1:0] in_ra,
  input  logic [RA-1:0] in_rb,
  input  logic [RA-1:0] in_rd,
  input  logic          in_wen,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [A:0]    alu_cmd,
  output logic [D-1:0]  inA,
  output logic [D-1:0]  inB,
  output logic          sc_i,
  output logic [RA-1:0] rd_q,
  output logic          wen_q,
  input  logic          wb_en,
  input  logic [RA-1:0] wb_addr,
  input  logic [D-1:0]  wb_data,
  input  logic          wb_sc_en,
  input  logic          wb_sc
);

  localparam int unsigned NREG = 2 ** RA;

  logic [D-1:0]  regs [NREG];
  logic          sc_flag;
  logic [RA-1:0] ra_q;
  logic [RA-1:0] rb_q;

  logic          accept;
  logic          hold;
  logic [D-1:0]  rd_a;
  logic [D-1:0]  rd_b;
  logic          rd_sc;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign hold     = out_valid && !out_ready && !flush;

  // Write-first read: a same-cycle write-back wins over the stored value
  always_comb begin
    rd_a  = regs[in_ra];
    rd_b  = regs[in_rb];
    rd_sc = sc_flag;
    if (wb_en && (wb_addr == in_ra)) rd_a = wb_data;
    if (wb_en && (wb_addr == in_rb)) rd_b = wb_data;
    if (wb_sc_en)                    rd_sc = wb_sc;
  end

  // Register file and flag: written independently of handshake, flush and stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      sc_flag <= 1'b0;
    end else begin
      if (wb_en)    regs[wb_addr] <= wb_data;
      if (wb_sc_en) sc_flag       <= wb_sc;
    end
  end

  // Held op: load on accept, refresh stalled operands from write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_cmd   <= '0;
      inA       <= '0;
      inB       <= '0;
      sc_i      <= 1'b0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      ra_q      <= '0;
      rb_q      <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (accept) begin
        alu_cmd <= in_cmd;
        rd_q    <= in_rd;
        wen_q   <= in_wen;
        ra_q    <= in_ra;
        rb_q    <= in_rb;
        inA     <= rd_a;
        inB     <= rd_b;
        sc_i    <= rd_sc;
      end else if (hold) begin
        if (wb_en && (wb_addr == ra_q)) inA  <= wb_data;
        if (wb_en && (wb_addr == rb_q)) inB  <= wb_data;
        if (wb_sc_en)                   sc_i <= wb_sc;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes expected held ops,
// a monitor pops and compares each op as the ALU consumes it.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       sc;
    logic [2:0] rd;
    logic       wen;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_cmd;
  logic [2:0] in_ra;
  logic [2:0] in_rb;
  logic [2:0] in_rd;
  logic       in_wen;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_cmd;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       sc_i;
  logic [2:0] rd_q;
  logic       wen_q;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       wb_sc_en;
  logic       wb_sc;

  int total = 0;
  int bad   = 0;
  exp_t sb [$];

  alu_operand_stage #(.A(3), .D(8), .RA(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_wen(in_wen),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .rd_q(rd_q), .wen_q(wen_q),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_sc_en(wb_sc_en), .wb_sc(wb_sc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] rd, input logic wen);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_ra    = ra;
    in_rb    = rb;
    in_rd    = rd;
    in_wen   = wen;
  endtask

  function automatic exp_t mk(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                              input logic sc, input logic [2:0] rd, input logic wen);
    exp_t e;
    e.cmd = cmd; e.a = a; e.b = b; e.sc = sc; e.rd = rd; e.wen = wen;
    return e;
  endfunction

  // Monitor: every consumed op must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t got;
      exp_t e;
      got = mk(alu_cmd, inA, inB, sc_i, rd_q, wen_q);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL consume_unexpected actual=%0h required=<none>", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL consume_op actual=%0h required=%0h (cmd,a,b,sc,rd,wen)", got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_cmd = '0; in_ra = '0; in_rb = '0; in_rd = '0;
    in_wen = 1'b0; flush = 1'b0; out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0;
    wb_data = '0; wb_sc_en = 1'b0; wb_sc = 1'b0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fields", {alu_cmd, inA, inB, sc_i, rd_q, wen_q}, 32'd0);

    // Read every register back-to-back: all zero after reset, full throughput
    step();
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      issue(4'(r), 3'(r), 3'(r), 3'(r), 1'b0);
      sb.push_back(mk(4'(r), 8'h00, 8'h00, 1'b0, 3'(r), 1'b0));
      @(negedge clk);
      if (r > 0) chk("b2b_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    in_valid = 1'b0;
    step();

    // Basic issue with backpressure
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'h12; step();
    wb_addr = 3'd2; wb_data = 8'h34; step();
    wb_en = 1'b0;
    out_ready = 1'b0;
    issue(4'b0011, 3'd1, 3'd2, 3'd5, 1'b1);
    sb.push_back(mk(4'b0011, 8'h12, 8'h34, 1'b0, 3'd5, 1'b1));
    step();
    issue(4'b1010, 3'd2, 3'd1, 3'd6, 1'b0);
    @(negedge clk);
    chk("issue_out_valid", 32'(out_valid), 32'd1);
    chk("issue_fields", {alu_cmd, inA, inB}, {12'h0, 4'b0011, 8'h12, 8'h34});
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_fields", {alu_cmd, inA, inB, rd_q}, {9'h0, 4'b0011, 8'h12, 8'h34, 3'd5});
    end
    step();
    out_ready = 1'b1;
    sb.push_back(mk(4'b1010, 8'h34, 8'h12, 1'b0, 3'd6, 1'b0));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("reload_out_valid", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_keeps_inA", 32'(inA), 32'h34);

    // Bypass at accept, same register on both sources
    step();
    issue(4'b0001, 3'd3, 3'd3, 3'd0, 1'b1);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'hA5;
    sb.push_back(mk(4'b0001, 8'hA5, 8'hA5, 1'b0, 3'd0, 1'b1));
    step();
    in_valid = 1'b0; wb_en = 1'b0;
    step();

    // Bypass into a stalled op
    out_ready = 1'b0;
    issue(4'b0010, 3'd1, 3'd2, 3'd7, 1'b1);
    sb.push_back(mk(4'b0010, 8'h12, 8'h77, 1'b0, 3'd7, 1'b1));
    step();
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h77;
    @(negedge clk);
    chk("stall_inB_before", 32'(inB), 32'h34);
    step();
    wb_en = 1'b0;
    @(negedge clk);
    chk("stall_inB_refresh", {inA, inB}, {16'h0, 8'h12, 8'h77});
    step();
    out_ready = 1'b1;
    step();
    step();

    // Flush discards the held op, blocks accept, keeps write-back
    out_ready = 1'b0;
    issue(4'b0101, 3'd1, 3'd1, 3'd1, 1'b0);
    step();
    issue(4'b0110, 3'd1, 3'd1, 3'd1, 1'b0);
    flush = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h5A;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    step();
    out_ready = 1'b1;
    issue(4'b0111, 3'd4, 3'd0, 3'd2, 1'b0);
    sb.push_back(mk(4'b0111, 8'h5A, 8'h00, 1'b0, 3'd2, 1'b0));
    step();
    in_valid = 1'b0;
    step();

    // Shift-carry flag: bypassed at accept, then persists
    issue(4'b1000, 3'd1, 3'd2, 3'd3, 1'b1);
    wb_sc_en = 1'b1; wb_sc = 1'b1;
    sb.push_back(mk(4'b1000, 8'h12, 8'h77, 1'b1, 3'd3, 1'b1));
    step();
    in_valid = 1'b0; wb_sc_en = 1'b0; wb_sc = 1'b0;
    step();
    issue(4'b1001, 3'd4, 3'd3, 3'd4, 1'b0);
    sb.push_back(mk(4'b1001, 8'h5A, 8'hA5, 1'b1, 3'd4, 1'b0));
    step();
    in_valid = 1'b0;
    step();

    // Reset mid-hold: op lost, registers and flag cleared
    out_ready = 1'b0;
    issue(4'b1111, 3'd2, 3'd1, 3'd5, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_sc_i", 32'(sc_i), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    issue(4'b0000, 3'd1, 3'd4, 3'd1, 1'b0);
    sb.push_back(mk(4'b0000, 8'h00, 8'h00, 1'b0, 3'd1, 1'b0));
    step();
    in_valid = 1'b0;
    step();
    step();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage that sits directly upstream of the 8-bit ALU.
- Holds the architectural register file and the shift-carry flag.
- Accepts decoded ops from decode, reads both source operands with write-back bypass, and presents them to the ALU from a one-entry pipeline register.
- Downstream handshake is valid/ready; ALU write-back returns results into this block.

Parameters:
A, 3, ALU command width minus one (command is A+1 bits)
D, 8, data width
RA, 3, register address width (2**RA registers)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decode presents an op
in_ready  output  1  stage accepts the op this cycle
in_cmd  input  A+1  ALU command
in_ra  input  RA  source register for inA
in_rb  input  RA  source register for inB
in_rd  input  RA  destination register
in_wen  input  1  op writes its result back
flush  input  1  discard the held op (branch redirect)
out_valid  output  1  held op is valid
out_ready  input  1  ALU/write-back consumes the held op
alu_cmd  output  A+1  held command
inA  output  D  held operand A
inB  output  D  held operand B
sc_i  output  1  held shift-carry flag
rd_q  output  RA  held destination
wen_q  output  1  held write enable
wb_en  input  1  write-back register write
wb_addr  input  RA  write-back register
wb_data  input  D  write-back data
wb_sc_en  input  1  write the shift-carry flag
wb_sc  input  1  new shift-carry value

Behaviour:
- Reset (async, immediate): all registers 0; sc flag 0; out_valid 0; alu_cmd, inA, inB, sc_i, rd_q, wen_q all 0.
- in_ready = !flush && (!out_valid || out_ready). Combinational; it has no dependence on in_valid.
- Accept: when in_valid && in_ready, on the next edge:
  - out_valid becomes 1.
  - alu_cmd, rd_q and wen_q are loaded.
  - Source addresses are latched internally.
  - inA and inB load the bypassed read values.
  - sc_i loads the bypassed flag.
- Latency: exactly 1 cycle from accept to out_valid.
- Consume without accept (out_valid && out_ready && !(in_valid && in_ready)): out_valid becomes 0 next edge; the held data fields keep their values.
- Back-to-back: consume and accept in the same cycle reload the stage; out_valid stays 1. This gives full throughput of one op per cycle.
- Hold (out_valid && !out_ready && !flush): all held fields are stable, with one exception:
  - If wb_en and wb_addr equals a latched source address, that operand updates to wb_data next edge.
  - If wb_sc_en, sc_i updates to wb_sc next edge.
  - This keeps operands coherent while stalled.
- Bypass at accept (write-first):
  - Operand = wb_data if wb_en && wb_addr equals the source address; otherwise the register file entry.
  - sc = wb_sc if wb_sc_en; otherwise the flag register.
- in_ra == in_rb is legal; both operands receive the same value, including the bypassed value.
- Register file:
  - Written on the edge when wb_en is set. All 2**RA entries are writable; there is no hard-wired zero.
  - wb_sc_en writes the flag on the same edge.
  - Write-back is independent of the handshake, flush and stall.
- Flush:
  - out_valid becomes 0 next edge, with priority over a hold.
  - in_ready is 0 while flush is high, so there is no accept that cycle.
  - Register file and flag writes in the same cycle still occur.
- Held fields never update from in_* unless an accept occurs.
- Reset asserted mid-operation: the held op is lost and the register file is cleared. in_ready returns to 1 once reset deasserts.

Test Plan:
1. Reset:
   - Pulse reset mid-hold -> out_valid=0 immediately.
   - All registers read 0 after reset.
   - in_ready=1 after reset.
2. Basic issue:
   - Write r1=0x12 and r2=0x34 via write-back.
   - Accept cmd=4'b0011, ra=1, rb=2 -> next cycle out_valid=1, inA=0x12, inB=0x34, alu_cmd=4'b0011.
3. Backpressure:
   - Hold out_valid=1 with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and fields stable.
   - Raise out_ready -> the new op is loaded next edge and out_valid stays 1.
4. Bypass:
   - Same-cycle wb_en, wb_addr=3, wb_data=0xA5 with an accept of ra=3 -> inA=0xA5.
   - During a stall, write r2=0x77 while the held rb=2 -> inB becomes 0x77 the next cycle.
5. Flush:
   - flush=1 with out_valid=1 and in_valid=1 -> in_ready=0, out_valid=0 next edge.
   - A same-cycle write-back of r4=0x5A is still visible on a later read.
6. Flag:
   - wb_sc_en=1, wb_sc=1 in the accept cycle -> sc_i=1.
   - Later accept with no flag write -> sc_i=1 (persists).
   - After reset -> sc_i=0.
